// File: rtl/airhockey_pkg.sv
// Shared types and constants for the air-hockey match sequencer.
// The PAUSE state exists only when MATCH_PAUSE_EN is defined.
package airhockey_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_GOAL  = 3'd3,
      ST_OVER  = 3'd4
`ifdef MATCH_PAUSE_EN
      , ST_PAUSE = 3'd5
`endif
   } state_e;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_P2   = 2'd2;

   localparam int unsigned BALL_CX = 315;
   localparam int unsigned BALL_CY = 230;

   typedef struct packed {
      logic [2:0] tens;
      logic [3:0] ones;
   } bcd_score_t;

   function automatic int unsigned bcd_value(input bcd_score_t s);
      return int'(s.tens) * 10 + int'(s.ones);
   endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score register: synchronous clear, +1 with 9->0 carry,
// saturating at 79.
module bcd_score_counter
   import airhockey_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       inc_i,
   output bcd_score_t score_o
);

   bcd_score_t score_q, score_d;

   always_comb begin
      score_d = score_q;
      if (clr_i) begin
         score_d = '0;
      end else if (inc_i) begin
         if (score_q.ones != 4'd9) begin
            score_d.ones = score_q.ones + 4'd1;
         end else if (score_q.tens != 3'd7) begin
            score_d.ones = 4'd0;
            score_d.tens = score_q.tens + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) score_q <= '0;
      else        score_q <= score_d;
   end

   assign score_o = score_q;

endmodule

// File: rtl/match_controller.sv
// Match sequencer: IDLE -> SERVE -> PLAY -> GOAL/OVER, BCD scoring, miss flash.
// Define MATCH_PAUSE_EN to add pause_btn and the PAUSE state.
module match_controller
   import airhockey_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = 10,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned GOAL_FRAMES  = 63
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start_btn,
`ifdef MATCH_PAUSE_EN
   input  logic       pause_btn,
`endif
   input  logic       goal_p1,
   input  logic       goal_p2,
   output logic       play_en,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic       miss_flash,
   output logic [3:0] p1_ones,
   output logic [2:0] p1_tens,
   output logic [3:0] p2_ones,
   output logic [2:0] p2_tens,
   output logic [1:0] winner,
   output logic [2:0] state_o
);

   state_e     state_q;
   logic [7:0] cnt_q;
   logic       play_en_q, ball_reset_q, serve_dir_q, miss_flash_q;
   logic [1:0] winner_q;
   logic [2:0] start_sync_q;
   logic       start_evt;
   bcd_score_t p1_score, p2_score;
   logic       score_clr, p1_inc, p2_inc, p1_win, p2_win;

   // [0],[1] synchronise the pin; [2] is the previous synchronised level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) start_sync_q <= '0;
      else        start_sync_q <= {start_sync_q[1:0], start_btn};
   end
   assign start_evt = start_sync_q[1] & ~start_sync_q[2];

`ifdef MATCH_PAUSE_EN
   logic [2:0] pause_sync_q;
   logic       pause_evt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pause_sync_q <= '0;
      else        pause_sync_q <= {pause_sync_q[1:0], pause_btn};
   end
   assign pause_evt = pause_sync_q[1] & ~pause_sync_q[2];
`endif

   assign score_clr = start_evt & ((state_q == ST_IDLE) | (state_q == ST_OVER));
   assign p1_inc    = (state_q == ST_PLAY) & goal_p1 & ~goal_p2;
   assign p2_inc    = (state_q == ST_PLAY) & goal_p2 & ~goal_p1;
   assign p1_win    = (bcd_value(p1_score) + 1) == WIN_SCORE;
   assign p2_win    = (bcd_value(p2_score) + 1) == WIN_SCORE;

   bcd_score_counter u_p1_score (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (score_clr),
      .inc_i  (p1_inc),
      .score_o(p1_score)
   );

   bcd_score_counter u_p2_score (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (score_clr),
      .inc_i  (p2_inc),
      .score_o(p2_score)
   );

   // Outputs are set on each transition so they line up with the new state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         play_en_q    <= 1'b0;
         ball_reset_q <= 1'b1;
         serve_dir_q  <= 1'b1;
         miss_flash_q <= 1'b0;
         winner_q     <= WIN_NONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               play_en_q    <= 1'b0;
               ball_reset_q <= 1'b1;
               miss_flash_q <= 1'b0;
               if (start_evt) begin
                  winner_q <= WIN_NONE;
                  cnt_q    <= 8'(SERVE_FRAMES);
                  state_q  <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (frame_tick) begin
                  if (cnt_q == 8'd1) begin
                     state_q      <= ST_PLAY;
                     play_en_q    <= 1'b1;
                     ball_reset_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
            end
            ST_PLAY: begin
               if (goal_p1 && goal_p2) begin
                  cnt_q        <= 8'(GOAL_FRAMES);
                  state_q      <= ST_GOAL;
                  play_en_q    <= 1'b0;
                  miss_flash_q <= 1'b1;
               end else if (goal_p1 || goal_p2) begin
                  serve_dir_q <= goal_p2;
                  play_en_q   <= 1'b0;
                  if ((goal_p1 && p1_win) || (goal_p2 && p2_win)) begin
                     winner_q     <= goal_p1 ? WIN_P1 : WIN_P2;
                     state_q      <= ST_OVER;
                     ball_reset_q <= 1'b1;
                  end else begin
                     cnt_q        <= 8'(GOAL_FRAMES);
                     state_q      <= ST_GOAL;
                     miss_flash_q <= 1'b1;
                  end
               end
`ifdef MATCH_PAUSE_EN
               else if (pause_evt) begin
                  state_q   <= ST_PAUSE;
                  play_en_q <= 1'b0;
               end
`endif
            end
            ST_GOAL: begin
               if (frame_tick) begin
                  if (cnt_q == 8'd1) begin
                     miss_flash_q <= 1'b0;
                     ball_reset_q <= 1'b1;
                     cnt_q        <= 8'(SERVE_FRAMES);
                     state_q      <= ST_SERVE;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
            end
            ST_OVER: begin
               if (start_evt) begin
                  winner_q <= WIN_NONE;
                  cnt_q    <= 8'(SERVE_FRAMES);
                  state_q  <= ST_SERVE;
               end
            end
`ifdef MATCH_PAUSE_EN
            ST_PAUSE: begin
               if (pause_evt) begin
                  state_q   <= ST_PLAY;
                  play_en_q <= 1'b1;
               end
            end
`endif
            default: begin
               state_q      <= ST_IDLE;
               play_en_q    <= 1'b0;
               ball_reset_q <= 1'b1;
               miss_flash_q <= 1'b0;
            end
         endcase
      end
   end

   assign play_en    = play_en_q;
   assign ball_reset = ball_reset_q;
   assign serve_dir  = serve_dir_q;
   assign miss_flash = miss_flash_q;
   assign p1_ones    = p1_score.ones;
   assign p1_tens    = p1_score.tens;
   assign p2_ones    = p2_score.ones;
   assign p2_tens    = p2_score.tens;
   assign winner     = winner_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Random-stimulus scoreboard bench for match_controller against an integer-score
// match model; build with MATCH_PAUSE_EN to exercise pause as well.
module tb_match_controller;

   localparam int WIN = 10;
   localparam int SF  = 3;
   localparam int GF  = 2;
   localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_GOAL = 3, M_OVER = 4, M_PAUSE = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   logic frame_tick = 1'b0, start_btn = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0;
`ifdef MATCH_PAUSE_EN
   logic pause_btn = 1'b0;
`endif
   logic       play_en, ball_reset, serve_dir, miss_flash;
   logic [3:0] p1_ones, p2_ones;
   logic [2:0] p1_tens, p2_tens, state_o;
   logic [1:0] winner;

   match_controller #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .GOAL_FRAMES(GF)) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
`ifdef MATCH_PAUSE_EN
      .pause_btn(pause_btn),
`endif
      .goal_p1(goal_p1), .goal_p2(goal_p2), .play_en(play_en), .ball_reset(ball_reset),
      .serve_dir(serve_dir), .miss_flash(miss_flash), .p1_ones(p1_ones), .p1_tens(p1_tens),
      .p2_ones(p2_ones), .p2_tens(p2_tens), .winner(winner), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       pe, br, sd, mf;
      logic [3:0] p1o;
      logic [2:0] p1t;
      logic [3:0] p2o;
      logic [2:0] p2t;
      logic [1:0] win;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0, errors = 0;
   int   cyc_no = 0;

   // match model: plain integer scores, phase number, frame countdown
   int m_st, m_cnt, m_p1, m_p2, m_win;
   bit m_sdir;
   bit spin_q[$];
   bit ppin_q[$];

   function automatic obs_t model_obs();
      obs_t o;
      o.st  = 3'(m_st);
      o.pe  = (m_st == M_PLAY);
      o.br  = (m_st == M_IDLE) || (m_st == M_SERVE) || (m_st == M_OVER);
      o.sd  = m_sdir;
      o.mf  = (m_st == M_GOAL);
      o.p1o = 4'(m_p1 % 10);
      o.p1t = 3'(m_p1 / 10);
      o.p2o = 4'(m_p2 % 10);
      o.p2t = 3'(m_p2 / 10);
      o.win = 2'(m_win);
      return o;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_sdir = 1'b1;
      spin_q = '{1'b0, 1'b0, 1'b0};
      ppin_q = '{1'b0, 1'b0, 1'b0};
   endtask

   // One clock edge with the input levels present at that edge; a button edge
   // takes effect at the third clock edge after the pin changes.
   task automatic model_step(input bit ft, input bit g1, input bit g2, input bit sp, input bit pp);
      bit sevt, pevt;
      sevt = spin_q[$-1] && !spin_q[$-2];
      pevt = ppin_q[$-1] && !ppin_q[$-2];
      spin_q.push_back(sp); if (spin_q.size() > 4) void'(spin_q.pop_front());
      ppin_q.push_back(pp); if (ppin_q.size() > 4) void'(ppin_q.pop_front());
      case (m_st)
         M_IDLE, M_OVER: if (sevt) begin
            m_p1 = 0; m_p2 = 0; m_win = 0; m_cnt = SF; m_st = M_SERVE;
         end
         M_SERVE: if (ft) begin
            if (m_cnt == 1) m_st = M_PLAY; else m_cnt--;
         end
         M_PLAY: begin
            if (g1 && g2) begin
               m_cnt = GF; m_st = M_GOAL;
            end else if (g1) begin
               m_p1++; m_sdir = 1'b0;
               if (m_p1 == WIN) begin m_win = 1; m_st = M_OVER; end
               else begin m_cnt = GF; m_st = M_GOAL; end
            end else if (g2) begin
               m_p2++; m_sdir = 1'b1;
               if (m_p2 == WIN) begin m_win = 2; m_st = M_OVER; end
               else begin m_cnt = GF; m_st = M_GOAL; end
            end
`ifdef MATCH_PAUSE_EN
            else if (pevt) m_st = M_PAUSE;
`endif
         end
         M_GOAL: if (ft) begin
            if (m_cnt == 1) begin m_cnt = SF; m_st = M_SERVE; end else m_cnt--;
         end
         M_PAUSE: if (pevt) m_st = M_PLAY;
         default: m_st = M_IDLE;
      endcase
   endtask

   // monitor: one observation per cycle, compared away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a.st = state_o; a.pe = play_en; a.br = ball_reset; a.sd = serve_dir;
            a.mf = miss_flash; a.p1o = p1_ones; a.p1t = p1_tens;
            a.p2o = p2_ones; a.p2t = p2_tens; a.win = winner;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs cycle %0d: got st=%0d pe=%b br=%b sd=%b mf=%b p1=%0d%0d p2=%0d%0d win=%0d, expected st=%0d pe=%b br=%b sd=%b mf=%b p1=%0d%0d p2=%0d%0d win=%0d",
                        cyc_no, a.st, a.pe, a.br, a.sd, a.mf, a.p1t, a.p1o, a.p2t, a.p2o, a.win,
                        e.st, e.pe, e.br, e.sd, e.mf, e.p1t, e.p1o, e.p2t, e.p2o, e.win);
            end
         end
      end
   end

   // driver: advance the model with the levels the DUT just sampled, queue the
   // expected outputs, then apply the next random inputs
   initial begin
      bit pp_now;
      bit mid_reset_done;
      int release_cyc;
      int max_score_seen;
      mid_reset_done = 1'b0;
      release_cyc    = 3;
      max_score_seen = 0;
      model_reset();
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(posedge clk); #1;
         cyc_no = cyc;
`ifdef MATCH_PAUSE_EN
         pp_now = pause_btn;
`else
         pp_now = 1'b0;
`endif
         if (rst_n) model_step(frame_tick, goal_p1, goal_p2, start_btn, pp_now);
         if (m_p1 > max_score_seen) max_score_seen = m_p1;
         // asynchronous reset in the middle of live play
         if (!mid_reset_done && cyc >= 3000 && (m_st == M_PLAY || cyc == 3600)) begin
            rst_n = 1'b0;
            model_reset();
            mid_reset_done = 1'b1;
            release_cyc = cyc + 2;
         end else if (cyc == release_cyc) begin
            rst_n = 1'b1;
         end
         exp_q.push_back(model_obs());
         if (rst_n) begin
            frame_tick = 1'($urandom_range(0, 1));
            goal_p1    = ($urandom_range(0, 5) == 0);
            goal_p2    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
`ifdef MATCH_PAUSE_EN
            if ($urandom_range(0, 19) == 0) pause_btn = ~pause_btn;
`endif
         end else begin
            frame_tick = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0; start_btn = 1'b0;
`ifdef MATCH_PAUSE_EN
            pause_btn = 1'b0;
`endif
         end
      end
      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d observations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences one air-hockey match around the existing ball/paddle/render datapath: idle, serve countdown, live play, goal pause, game over.
- Owns the BCD scoreboard and the miss-flash window.
- Gates ball motion with play_en and ball_reset.
- Consumes per-frame ticks and goal pulses from the datapath; drives the seven-segment score nets.

Parameters:
- WIN_SCORE, 10, points that end the match; legal range 1..79.
- SERVE_FRAMES, 60, frames held in SERVE before play resumes; legal range 1..255.
- GOAL_FRAMES, 63, frames of miss flash after a goal; legal range 1..255.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- frame_tick  in  1  one-cycle pulse at end of each video frame (x=0, y=480).
- start_btn  in  1  debounced start level; asynchronous; synchronised internally.
- goal_p1  in  1  one-cycle pulse: ball touched right wall, so P1 scores.
- goal_p2  in  1  one-cycle pulse: ball touched left wall, so P2 scores.
- play_en  out  1  ball may move and collide.
- ball_reset  out  1  hold ball at centre (315,230).
- serve_dir  out  1  initial X direction for the next serve: 1 = rightward.
- miss_flash  out  1  render the miss colour.
- p1_ones  out  4  P1 score, BCD ones.
- p1_tens  out  3  P1 score, BCD tens.
- p2_ones  out  4  P2 score, BCD ones.
- p2_tens  out  3  P2 score, BCD tens.
- winner  out  2  0 none, 1 P1, 2 P2.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, all scores 0, winner 0, play_en 0, ball_reset 1, serve_dir 1, miss_flash 0, frame counter 0.
- A reset asserted mid-match returns everything to these values immediately. It is asynchronous and does not wait for the clock.
- start_btn passes through a 2-flop synchroniser. A rising-edge detector produces start_evt, which is 3 cycles of latency after the pin.
- States and encoding: IDLE=0, SERVE=1, PLAY=2, GOAL=3, OVER=4. Illegal encodings go to IDLE on the next clock.
- IDLE:
  - ball_reset=1, play_en=0.
  - On start_evt: clear scores and winner, load counter with SERVE_FRAMES, go to SERVE.
- SERVE:
  - ball_reset=1, play_en=0.
  - Each frame_tick decrements the counter.
  - A frame_tick that arrives while the counter is 1 moves the block to PLAY. SERVE therefore lasts exactly SERVE_FRAMES ticks.
- PLAY:
  - play_en=1, ball_reset=0.
  - goal_p1 alone: P1 score +1, serve_dir<=0 (serve toward the scorer's side).
  - goal_p2 alone: P2 score +1, serve_dir<=1.
  - goal_p1 and goal_p2 in the same cycle: neither score changes, serve_dir unchanged, go to GOAL.
  - If the incremented score equals WIN_SCORE: go to OVER and set winner.
  - Otherwise: load counter with GOAL_FRAMES, go to GOAL.
  - play_en drops in the cycle after the goal pulse.
- GOAL:
  - play_en=0, ball_reset=0 (ball frozen in place), miss_flash=1.
  - Counter decrements on frame_tick. On the tick at count 1: miss_flash<=0, load SERVE_FRAMES, go to SERVE.
- OVER:
  - play_en=0, ball_reset=1, miss_flash=0.
  - Scores and winner held.
  - On start_evt: clear scores and winner, go to SERVE.
- Goal pulses arriving outside PLAY are ignored.
- start_evt outside IDLE and OVER is ignored.
- BCD increment:
  - Ones 9 wraps to 0 and increments tens.
  - Tens saturate at 7 and ones at 9 (79). Saturation is unreachable given the WIN_SCORE range.
- WIN_SCORE is compared as tens*10+ones, computed combinationally from the BCD values.
- A frame_tick in the same cycle as a goal pulse: the goal takes priority and the counter loads, it does not decrement.

Optional Feature:
- Macro: MATCH_PAUSE_EN.
- When defined:
  - Adds input pause_btn (1 bit, asynchronous level, synchronised and edge-detected like start_btn).
  - Adds state PAUSE=5.
  - A pause edge in PLAY goes to PAUSE: play_en=0, ball position held.
  - A pause edge in PAUSE returns to PLAY.
  - Goal pulses and frame_tick are ignored in PAUSE.
  - start_evt in PAUSE is ignored.
- When undefined: no port, no PAUSE state, encoding 5 is illegal and goes to IDLE.

Decomposition:
- Shared package airhockey_pkg holds:
  - the state enum and encodings;
  - the winner codes;
  - the centre coordinates 315/230;
  - a bcd_score_t struct (ones[3:0], tens[2:0]).
- One sub-module, bcd_score_counter: synchronous clear and increment, 9->0 carry, saturation at 79, instantiated once per player.
- The edge-synchroniser is inlined in match_controller.

Test Plan:
- Reset with a pulse while in PLAY -> next clock shows state 0, ball_reset=1, play_en=0, all scores 0, winner 0.
- start_btn high with SERVE_FRAMES=3 -> SERVE 3 cycles after the pin; PLAY exactly on the 3rd frame_tick; play_en=1 the following cycle.
- In PLAY, one goal_p1 with GOAL_FRAMES=2 -> p1_ones=1, miss_flash=1, serve_dir=0; after 2 ticks SERVE with miss_flash=0.
- P1 at 09 takes goal_p1 -> p1_ones=0, p1_tens=1. With WIN_SCORE=10 -> OVER, winner=1, play_en=0; a later start edge clears the scores and enters SERVE.
- goal_p1 and goal_p2 in the same cycle -> scores unchanged, GOAL entered, serve_dir unchanged. A goal pulse during SERVE -> no effect.
- MATCH_PAUSE_EN defined, pause edge in PLAY -> state 5, play_en=0; frame_tick and goal_p2 are ignored; a second pause edge returns to PLAY.
